reg_alu_unit: RTL and testbench

REG_ALU_UNIT -- requirements
Module: reg_alu_unit

---
 rtl/reg_alu_pkg.sv | 21 ++
 rtl/reg_alu_mul_seq.sv | 47 ++++
 rtl/reg_alu_unit.sv | 163 ++++++++++++++++
 tb/tb_reg_alu_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_pkg.sv
// reg_alu_pkg: opcodes, FSM states and default sizes shared by the reg_alu blocks.
package reg_alu_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_NOR  = 4'd3,
        OP_ADD  = 4'd4,
        OP_SUB  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_INC  = 4'd11,
        OP_MUL  = 4'd12
    } op_e;
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;
endpackage

// File: rtl/reg_alu_mul_seq.sv
// reg_alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle for WIDTH cycles.
// done_o/prod_o are valid combinationally during the final iteration so the caller can write at that edge.
module reg_alu_mul_seq
    import reg_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done_o = run_q && cnt_q == CW'(1);
    assign prod_o = acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i && !run_q) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            acc_q    <= '0;
            mplier_q <= b_i;
            cnt_q    <= CW'(WIDTH);
            run_q    <= 1'b1;
        end else if (run_q) begin
            mcand_q  <= mcand_q << 1;
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            run_q    <= cnt_q != CW'(1);
        end
    end
endmodule

// File: rtl/reg_alu_unit.sv
// reg_alu_unit: register file with a single-issue ALU plus external load and debug read ports.
// Define REG_ALU_MUL_EN to add the iterative MUL opcode; otherwise opcode 12 is illegal.
module reg_alu_unit
    import reg_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rs_a,
    input  logic [AW-1:0]    rs_b,
    input  logic [AW-1:0]    rd,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             ZF,
    output logic             NF,
    output logic             CF,
    output logic             OF
);
    localparam int SW = $clog2(WIDTH);
`ifdef REG_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   result_q, opa, opb, alu_res, wb_data;
    logic [WIDTH:0]     add_w, sub_w, inc_w;
    logic [SW-1:0]      shamt;
    logic [AW-1:0]      wb_addr, mul_rd;
    logic [2*WIDTH-1:0] mul_prod;
    logic zf_q, nf_q, cf_q, of_q, done_q, err_q;
    logic alu_c, alu_v, legal, in_idle, accept, wb_alu, wb_en, mul_done, cf_d, of_d;

    assign opa      = regs_q[rs_a];
    assign opb      = regs_q[rs_b];
    assign shamt    = opb[SW-1:0];
    assign dbg_data = regs_q[dbg_addr];
    assign add_w    = {1'b0, opa} + {1'b0, opb};
    assign sub_w    = {1'b0, opa} - {1'b0, opb};
    assign inc_w    = {1'b0, opa} + (WIDTH+1)'(1);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        legal   = 1'b1;
        case (op)
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_NOR:  alu_res = ~(opa | opb);
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (add_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (sub_w[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(opa) < $signed(opb));
            OP_SLTU: alu_res = WIDTH'(opa < opb);
            OP_SLL:  alu_res = opa << shamt;
            OP_SRL:  alu_res = opa >> shamt;
            OP_SRA:  alu_res = $signed(opa) >>> shamt;
            OP_INC: begin
                alu_res = inc_w[WIDTH-1:0];
                alu_c   = inc_w[WIDTH];
                alu_v   = !opa[WIDTH-1] && inc_w[WIDTH-1];
            end
            OP_MUL:  legal = MUL_EN;
            default: legal = 1'b0;
        endcase
    end

    // MUL and an accepted op can never share an edge: accept needs IDLE, mul_done needs MUL
    assign accept  = start && in_idle;
    assign wb_alu  = accept && legal && op != OP_MUL;
    assign wb_en   = wb_alu || mul_done;
    assign wb_addr = mul_done ? mul_rd : rd;
    assign wb_data = mul_done ? mul_prod[WIDTH-1:0] : alu_res;
    assign cf_d    = mul_done ? 1'b0 : alu_c;
    assign of_d    = mul_done ? |mul_prod[2*WIDTH-1:WIDTH] : alu_v;

`ifdef REG_ALU_MUL_EN
    state_e        state_q;
    logic [AW-1:0] rd_q;
    logic          mul_go;
    assign mul_go  = accept && legal && op == OP_MUL;
    assign in_idle = state_q == S_IDLE;
    assign busy    = state_q == S_MUL;
    assign mul_rd  = rd_q;
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
        end else if (mul_go) begin
            state_q <= S_MUL;
            rd_q    <= rd;
        end else if (mul_done) begin
            state_q <= S_IDLE;
        end
    end
    reg_alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n_i (Reset_n),
        .start_i (mul_go),
        .a_i     (opa),
        .b_i     (opb),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign in_idle  = 1'b1;
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_rd   = '0;
    assign mul_prod = '0;
`endif

    // an ALU writeback always wins the port, even when it targets r0
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            result_q <= '0;
            {zf_q, nf_q, cf_q, of_q, done_q, err_q} <= '0;
        end else begin
            done_q <= wb_en || (accept && !legal);
            err_q  <= accept && !legal;
            if (wb_en) begin
                if (wb_addr != '0) regs_q[wb_addr] <= wb_data;
                result_q <= wb_data;
                zf_q     <= wb_data == '0;
                nf_q     <= wb_data[WIDTH-1];
                cf_q     <= cf_d;
                of_q     <= of_d;
            end else if (ext_we && ext_addr != '0) begin
                regs_q[ext_addr] <= ext_data;
            end
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
    assign ZF     = zf_q;
    assign NF     = nf_q;
    assign CF     = cf_q;
    assign OF     = of_q;
endmodule

// File: tb/tb_reg_alu_unit.sv
// tb_reg_alu_unit: directed and random ops checked against an arithmetic reference model.
// MUL expectations follow REG_ALU_MUL_EN, as for the design.
module tb_reg_alu_unit;
    logic        clk = 1'b0;
    logic        Reset_n, start, ext_we;
    logic [3:0]  op;
    logic [4:0]  rs_a, rs_b, rd, ext_addr, dbg_addr;
    logic [31:0] ext_data, dbg_data, result;
    logic        busy, done, err, ZF, NF, CF, OF;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mregs [32];
    logic [31:0] mres;
    bit          mz, mn, mc, mv;

    always #5 clk = ~clk;

    reg_alu_unit dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .op(op),
        .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .done(done), .err(err), .result(result),
        .ZF(ZF), .NF(NF), .CF(CF), .OF(OF)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // overflow is judged by whether the exact signed value survives wrapping to 32 bits
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit c, output bit v, output bit lg);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; c = 0; v = 0; lg = 1; s = 0; p = '0;
        case (o)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            4'd4: begin s = sa + sb; r = a + b; c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF; v = s != longint'($signed(r)); end
            4'd5: begin s = sa - sb; r = a - b; c = a < b; v = s != longint'($signed(r)); end
            4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd11: begin s = sa + 1; r = a + 1; c = a == 32'hFFFF_FFFF; v = s != longint'($signed(r)); end
`ifdef REG_ALU_MUL_EN
            4'd12: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; v = p[63:32] != 0; end
`endif
            default: lg = 0;
        endcase
    endfunction

    task automatic ext_load(input logic [4:0] a, input logic [31:0] v);
        ext_we = 1; ext_addr = a; ext_data = v;
        tick();
        ext_we = 0;
        if (a != 0) mregs[a] = v;
        dbg_addr = a;
        #1 chk("ext_load", dbg_data, mregs[a]);
    endtask

    task automatic do_op(input logic [3:0] o, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] d, input bit col, input bit retrig);
        logic [31:0] r;
        bit c, v, lg, ismul;
        int n, bn;
        model(o, mregs[sa], mregs[sb], r, c, v, lg);
        ismul = lg && o == 4'd12;
        op = o; rs_a = sa; rs_b = sb; rd = d; start = 1;
        if (col) begin ext_we = 1; ext_addr = d; ext_data = 32'hDEAD_BEEF; end
        tick();
        start = 0; ext_we = 0;
        if (col && (!lg || ismul) && d != 0) mregs[d] = 32'hDEAD_BEEF;
        n = 1; bn = busy;
        while (!done && n < 80) begin
            start = (retrig && n == 5);
            tick();
            n++; bn += busy;
        end
        start = 0;
        chk("latency", n, ismul ? 33 : 1);
        chk("busy_cycles", bn, ismul ? 32 : 0);
        chk("done", done, 1);
        chk("err", err, !lg);
        if (lg) begin
            if (d != 0) mregs[d] = r;
            mres = r; mz = r == 0; mn = r[31]; mc = c; mv = v;
        end
        chk("result", result, mres);
        chk("ZF", ZF, mz);
        chk("NF", NF, mn);
        chk("CF", CF, mc);
        chk("OF", OF, mv);
        dbg_addr = d;
        #1 chk("rd_value", dbg_data, mregs[d]);
        tick();
        chk("done_low", done, 0);
        chk("err_low", err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        Reset_n = 0; start = 0; ext_we = 0; op = 0; rs_a = 0; rs_b = 0; rd = 0;
        ext_addr = 0; ext_data = 0; dbg_addr = 0;
        foreach (mregs[i]) mregs[i] = '0;
        mres = '0; mz = 0; mn = 0; mc = 0; mv = 0;
        tick(); tick();
        Reset_n = 1;
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {ZF, NF, CF, OF}, 0);
        ext_load(5'd1, 32'd5);
        ext_load(5'd2, 32'd3);
        do_op(4'd4, 5'd1, 5'd2, 5'd3, 0, 0);
        chk("add_r3", mregs[3], 32'd8);
        ext_load(5'd1, 32'h7FFF_FFFF);
        ext_load(5'd2, 32'd1);
        do_op(4'd4, 5'd1, 5'd2, 5'd4, 0, 0);
        do_op(4'd5, 5'd2, 5'd2, 5'd5, 0, 0);
        ext_load(5'd1, 32'hFFFF_FFFF);
        ext_load(5'd6, 32'd4);
        do_op(4'd6, 5'd1, 5'd2, 5'd7, 0, 0);
        do_op(4'd7, 5'd1, 5'd2, 5'd8, 0, 0);
        do_op(4'd10, 5'd1, 5'd6, 5'd9, 0, 0);
        do_op(4'd1, 5'd1, 5'd2, 5'd0, 0, 0);
        ext_load(5'd0, 32'h1234_5678);
        ext_load(5'd1, 32'd10);
        op = 4'd4; rs_a = 5'd1; rs_b = 5'd1; rd = 5'd7; start = 1;
        tick();
        chk("b2b_done1", done, 1);
        rs_a = 5'd7; rs_b = 5'd7; rd = 5'd8;
        tick();
        start = 0;
        chk("b2b_done2", done, 1);
        chk("b2b_result", result, 32'd40);
        mregs[7] = 32'd20; mregs[8] = 32'd40; mres = 32'd40; mz = 0; mn = 0; mc = 0; mv = 0;
        dbg_addr = 5'd7;
        #1 chk("b2b_r7", dbg_data, 32'd20);
        tick();
        chk("b2b_done_low", done, 0);
        ext_load(5'd9, 32'h0001_0000);
        ext_load(5'd10, 32'h0001_0000);
        do_op(4'd12, 5'd9, 5'd10, 5'd11, 0, 1);
        ext_load(5'd1, 32'd5);
        ext_load(5'd2, 32'd3);
        do_op(4'd4, 5'd1, 5'd2, 5'd3, 1, 0);
        do_op(4'd14, 5'd1, 5'd2, 5'd12, 0, 0);
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) < 3)
                ext_load(5'($urandom_range(0, 31)), $urandom);
            else
                do_op(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      5'($urandom_range(0, 31)), $urandom_range(0, 4) == 0, 0);
        end
`ifdef REG_ALU_MUL_EN
        ext_load(5'd3, 32'd7);
        ext_load(5'd4, 32'd9);
        op = 4'd12; rs_a = 5'd3; rs_b = 5'd4; rd = 5'd5; start = 1;
        tick();
        start = 0;
        chk("mul_busy", busy, 1);
        repeat (5) tick();
`endif
        Reset_n = 0;
        tick();
        Reset_n = 1;
        chk("rst2_busy", busy, 0);
        chk("rst2_done", done, 0);
        chk("rst2_result", result, 0);
        chk("rst2_flags", {ZF, NF, CF, OF}, 0);
        n = 0;
        repeat (40) begin tick(); n += done; end
        chk("rst2_no_done", n, 0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk("rst2_reg", dbg_data, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
